// File: rtl/alu_pkg.sv
// Shared definitions for the two-port ALU arbiter: data width, operation
// codes, the defined-code check and the response slot state type.
package alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_SLT  = 4'b0100;
   localparam logic [3:0] OP_SRA  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b0111;
   localparam logic [3:0] OP_SUBU = 4'b1001;
   localparam logic [3:0] OP_XOR  = 4'b1010;
   localparam logic [3:0] OP_SLTU = 4'b1100;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   // True when ctrl names one of the supported operations
   function automatic logic is_defined_op(input logic [3:0] ctrl);
      case (ctrl)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SRA,
         OP_SRL, OP_SLL, OP_SUBU, OP_XOR, OP_SLTU: is_defined_op = 1'b1;
         default:                                  is_defined_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU shared by both arbiter ports. Comparison
// flags always describe a versus b, independent of the operation selected.
module alu_arbiter_alu
   import alu_pkg::*;
(
   input  logic [3:0]        ctrl,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              neg,
   output logic              neg_u,
   output logic              err
);

   logic [4:0] shamt;

   assign shamt = b[4:0];
   assign zero  = (a == b);
   assign neg   = ($signed(a) < $signed(b));
   assign neg_u = (a < b);
   assign err   = ~is_defined_op(ctrl);

   // Operation select; undefined codes produce a zero result
   always_comb begin
      result = '0;
      case (ctrl)
         OP_ADD:          result = a + b;
         OP_SUB, OP_SUBU: result = a - b;
         OP_AND:          result = a & b;
         OP_OR:           result = a | b;
         OP_XOR:          result = a ^ b;
         OP_SLT:          result = {{(DATA_W-1){1'b0}}, neg};
         OP_SLTU:         result = {{(DATA_W-1){1'b0}}, neg_u};
         OP_SRA:          result = $unsigned($signed(a) >>> shamt);
         OP_SRL:          result = a >> shamt;
         OP_SLL:          result = a << shamt;
         default:         result = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port front end for a single shared ALU. Each port owns a one-entry
// response slot; at most one request is granted per cycle, either with
// round-robin or fixed priority to port 0, and its result appears one cycle
// later in that port's slot.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int RR_EN = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req0_valid,
   input  logic [3:0]        i_req0_ctrl,
   input  logic [DATA_W-1:0] i_req0_a,
   input  logic [DATA_W-1:0] i_req0_b,
   output logic              o_req0_ready,
   output logic              o_rsp0_valid,
   output logic [DATA_W-1:0] o_rsp0_result,
   output logic              o_rsp0_zero,
   output logic              o_rsp0_neg,
   output logic              o_rsp0_negU,
   output logic              o_rsp0_err,
   input  logic              i_rsp0_ready,
   input  logic              i_req1_valid,
   input  logic [3:0]        i_req1_ctrl,
   input  logic [DATA_W-1:0] i_req1_a,
   input  logic [DATA_W-1:0] i_req1_b,
   output logic              o_req1_ready,
   output logic              o_rsp1_valid,
   output logic [DATA_W-1:0] o_rsp1_result,
   output logic              o_rsp1_zero,
   output logic              o_rsp1_neg,
   output logic              o_rsp1_negU,
   output logic              o_rsp1_err,
   input  logic              i_rsp1_ready
);

   slot_state_t [1:0]             slot_state;
   logic [1:0]                    rsp_valid;
   logic [1:0][DATA_W-1:0]        rsp_result;
   logic [1:0]                    rsp_zero;
   logic [1:0]                    rsp_neg;
   logic [1:0]                    rsp_neg_u;
   logic [1:0]                    rsp_err;
   logic                          prio;
   logic [1:0]                    req_valid;
   logic [1:0]                    rsp_ready;
   logic [1:0]                    eligible;
   logic [1:0]                    grant;
   logic                          port1_wins;
   logic [3:0]                    sel_ctrl;
   logic [DATA_W-1:0]             sel_a;
   logic [DATA_W-1:0]             sel_b;
   logic [DATA_W-1:0]             alu_result;
   logic                          alu_zero;
   logic                          alu_neg;
   logic                          alu_neg_u;
   logic                          alu_err;

   assign req_valid = {i_req1_valid, i_req0_valid};
   assign rsp_ready = {i_rsp1_ready, i_rsp0_ready};

   // Eligibility and grant: a port may issue when its slot is free or being
   // drained this cycle; operand values never reach this logic
   always_comb begin
      eligible   = '0;
      grant      = '0;
      port1_wins = (RR_EN != 0) && prio;
      for (int p = 0; p < 2; p++) begin
         eligible[p] = ~i_rst & req_valid[p] & (~rsp_valid[p] | rsp_ready[p]);
      end
      if (eligible[0] && eligible[1]) begin
         grant[1] = port1_wins;
         grant[0] = ~port1_wins;
      end else begin
         grant = eligible;
      end
   end

   assign o_req0_ready = grant[0];
   assign o_req1_ready = grant[1];

   assign sel_ctrl = grant[1] ? i_req1_ctrl : i_req0_ctrl;
   assign sel_a    = grant[1] ? i_req1_a    : i_req0_a;
   assign sel_b    = grant[1] ? i_req1_b    : i_req0_b;

   alu_arbiter_alu u_alu (
      .ctrl   (sel_ctrl),
      .a      (sel_a),
      .b      (sel_b),
      .result (alu_result),
      .zero   (alu_zero),
      .neg    (alu_neg),
      .neg_u  (alu_neg_u),
      .err    (alu_err)
   );

   // Round-robin pointer: after a grant, favour the other port next time
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prio <= 1'b0;
      end else if (grant[0]) begin
         prio <= 1'b1;
      end else if (grant[1]) begin
         prio <= 1'b0;
      end
   end

   // Per-port response slot state machine with registered result and flags
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         slot_state <= {SLOT_EMPTY, SLOT_EMPTY};
         rsp_valid  <= '0;
         rsp_result <= '0;
         rsp_zero   <= '0;
         rsp_neg    <= '0;
         rsp_neg_u  <= '0;
         rsp_err    <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            case (slot_state[p])
               SLOT_EMPTY: begin
                  if (grant[p]) begin
                     slot_state[p] <= SLOT_FULL;
                     rsp_valid[p]  <= 1'b1;
                  end
               end
               SLOT_FULL: begin
                  if (!grant[p] && rsp_ready[p]) begin
                     slot_state[p] <= SLOT_EMPTY;
                     rsp_valid[p]  <= 1'b0;
                  end
               end
               default: begin
                  slot_state[p] <= SLOT_EMPTY;
                  rsp_valid[p]  <= 1'b0;
               end
            endcase
            if (grant[p]) begin
               rsp_result[p] <= alu_result;
               rsp_zero[p]   <= alu_zero;
               rsp_neg[p]    <= alu_neg;
               rsp_neg_u[p]  <= alu_neg_u;
               rsp_err[p]    <= alu_err;
            end
         end
      end
   end

   assign o_rsp0_valid  = rsp_valid[0];
   assign o_rsp0_result = rsp_result[0];
   assign o_rsp0_zero   = rsp_zero[0];
   assign o_rsp0_neg    = rsp_neg[0];
   assign o_rsp0_negU   = rsp_neg_u[0];
   assign o_rsp0_err    = rsp_err[0];
   assign o_rsp1_valid  = rsp_valid[1];
   assign o_rsp1_result = rsp_result[1];
   assign o_rsp1_zero   = rsp_zero[1];
   assign o_rsp1_neg    = rsp_neg[1];
   assign o_rsp1_negU   = rsp_neg_u[1];
   assign o_rsp1_err    = rsp_err[1];

endmodule
